// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch port and program-load stream between host/mproc and prog_mem
interface prog_mem_if;
   logic [15:0] addr;
   logic [15:0] ins;
   logic        ld_start;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_done;
   logic        busy;
   modport master (output addr, ld_start, ld_valid, ld_data, ld_last,
                   input  ins, ld_ready, ld_done, busy);
   modport slave  (input  addr, ld_start, ld_valid, ld_data, ld_last,
                   output ins, ld_ready, ld_done, busy);
endinterface

// File: rtl/prog_mem.sv
// prog_mem: loadable instruction store returning a combinational fetch word, NOP when empty
module prog_mem #(
   parameter int          AW       = 4,
   parameter logic [15:0] NOP_WORD = 16'hF800
) (
   input logic        clk,
   input logic        reset,
   prog_mem_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t          state, state_nxt;
   logic [15:0]     mem [2**AW];
   logic [AW-1:0]   wptr;
   logic            done_q;
   logic            acc, fin;
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end
   // next state: a start always (re)enters LOAD and beats any coincident word
   always_comb begin
      acc       = (state == LOAD) && bus.ld_valid && !bus.ld_start;
      fin       = acc && (bus.ld_last || wptr == '1);
      state_nxt = bus.ld_start ? LOAD : fin ? RUN : state;
   end
   // outputs: fetches only see the array once a load has completed
   always_comb begin
      bus.ld_ready = state == LOAD;
      bus.busy     = state != RUN;
      bus.ins      = (state == RUN && bus.addr[15:AW] == '0) ? mem[bus.addr[AW-1:0]] : NOP_WORD;
      bus.ld_done  = done_q;
   end
   // array, write pointer and completion pulse; a start wipes any earlier program
   always_ff @(posedge clk) begin
      done_q <= !reset && fin;
      if (reset || bus.ld_start) begin
         wptr <= '0;
         for (int i = 0; i < 2**AW; i++) mem[i] <= NOP_WORD;
      end else if (acc) begin
         mem[wptr] <= bus.ld_data;
         wptr      <= wptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed load/fetch scenarios checked through an expectation queue
module tb_prog_mem;
   typedef struct {
      string       n;
      logic [15:0] ins;
      logic        busy;
      logic        rdy;
      logic        done;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   exp_t q[$];
   exp_t it;
   int   total = 0;
   int   passed = 0;
   prog_mem_if bus();
   prog_mem #(.AW(4), .NOP_WORD(16'hF800)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [15:0] i, input logic b, input logic r, input logic d);
      q.push_back('{n, i, b, r, d});
   endtask
   task automatic word(input logic [15:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
   endtask
   // monitor: one expectation per sampled cycle; any ld_done pulse nobody expected is a failure
   always @(negedge clk) begin
      if (q.size() > 0) begin
         it = q.pop_front();
         total++;
         if (bus.ins !== it.ins || bus.busy !== it.busy || bus.ld_ready !== it.rdy || bus.ld_done !== it.done)
            $display("FAIL %s: got ins=%h busy=%b rdy=%b done=%b, want ins=%h busy=%b rdy=%b done=%b",
                     it.n, bus.ins, bus.busy, bus.ld_ready, bus.ld_done, it.ins, it.busy, it.rdy, it.done);
         else
            passed++;
      end else if (bus.ld_done !== 1'b0 && reset === 1'b0) begin
         total++;
         $display("FAIL stray_done: got ld_done=%b, want 0", bus.ld_done);
      end
   end
   initial begin
      reset = 1'b1;
      bus.addr = '0; bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
      tick; tick;
      reset = 1'b0;
      chk("reset", 16'hF800, 1, 0, 0); tick;
      bus.addr = 16'h0002;
      chk("idle_addr", 16'hF800, 1, 0, 0); tick;
      bus.ld_start = 1'b1;
      chk("idle_start", 16'hF800, 1, 0, 0); tick;
      bus.ld_start = 1'b0;
      word(16'h0041, 0); chk("short_w0", 16'hF800, 1, 1, 0); tick;
      bus.ld_valid = 1'b0; chk("short_gap", 16'hF800, 1, 1, 0); tick;
      word(16'h0250, 0); chk("short_w1", 16'hF800, 1, 1, 0); tick;
      word(16'h0683, 1); chk("short_w2", 16'hF800, 1, 1, 0); tick;
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      bus.addr = 16'h0000; chk("short_rd0", 16'h0041, 0, 0, 1); tick;
      bus.addr = 16'h0001; chk("short_rd1", 16'h0250, 0, 0, 0); tick;
      bus.addr = 16'h0002; chk("short_rd2", 16'h0683, 0, 0, 0); tick;
      bus.addr = 16'h0003; chk("short_rd3", 16'hF800, 0, 0, 0); tick;
      bus.addr = 16'h0010; chk("oor_0010", 16'hF800, 0, 0, 0); tick;
      bus.addr = 16'hFFFF; chk("oor_ffff", 16'hF800, 0, 0, 0); tick;
      bus.addr = 16'h0012; chk("oor_0012", 16'hF800, 0, 0, 0); tick;
      bus.addr = 16'h0003; word(16'h1234, 1); chk("run_ignore", 16'hF800, 0, 0, 0); tick;
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      chk("run_ignore_after", 16'hF800, 0, 0, 0); tick;
      bus.addr = 16'h0000; bus.ld_start = 1'b1;
      chk("full_start", 16'h0041, 0, 0, 0); tick;
      bus.ld_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.addr = 16'(i);
         word(16'h1000 + 16'(i), 0);
         chk($sformatf("full_w%0d", i), 16'hF800, 1, 1, 0); tick;
      end
      bus.ld_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.addr = 16'(i);
         chk($sformatf("full_rd%0d", i), 16'h1000 + 16'(i), 0, 0, i == 0); tick;
      end
      bus.addr = 16'h0000; bus.ld_start = 1'b1;
      chk("rst_start", 16'h1000, 0, 0, 0); tick;
      bus.ld_start = 1'b0;
      word(16'h0B01, 0); chk("rst_w0", 16'hF800, 1, 1, 0); tick;
      word(16'h0B02, 0); chk("rst_w1", 16'hF800, 1, 1, 0); tick;
      bus.ld_start = 1'b1; word(16'hAAAA, 0); chk("rst_drop", 16'hF800, 1, 1, 0); tick;
      bus.ld_start = 1'b0;
      word(16'h0C00, 0); chk("rst_w2", 16'hF800, 1, 1, 0); tick;
      word(16'h0C01, 1); chk("rst_w3", 16'hF800, 1, 1, 0); tick;
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.addr = 16'(i);
         chk($sformatf("rst_rd%0d", i), i == 0 ? 16'h0C00 : i == 1 ? 16'h0C01 : 16'hF800, 0, 0, i == 0); tick;
      end
      bus.ld_start = 1'b1; chk("mid_start", 16'hF800, 0, 0, 0); tick;
      bus.ld_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         word(16'hD000 + 16'(i), 0);
         chk($sformatf("mid_w%0d", i), 16'hF800, 1, 1, 0); tick;
      end
      reset = 1'b1; word(16'hD005, 1);
      chk("mid_reset", 16'hF800, 1, 1, 0); tick;
      reset = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      chk("mid_idle", 16'hF800, 1, 0, 0); tick;
      bus.ld_start = 1'b1; chk("mid_restart", 16'hF800, 1, 0, 0); tick;
      bus.ld_start = 1'b0;
      word(16'h0E00, 1); chk("mid_one", 16'hF800, 1, 1, 0); tick;
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.addr = 16'(i);
         chk($sformatf("mid_rd%0d", i), i == 0 ? 16'h0E00 : 16'hF800, 0, 0, i == 0); tick;
      end
      tick; tick;
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
